// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer
//   Write controller for a bank of NUM_LATCH transparent D latches sharing
//   one WIDTH-bit data bus. A request taken over wr_valid/wr_ready is put on
//   lat_d, then one gate line is opened, then closed again. lat_d stays
//   stable SETUP_CYC cycles before the gate opens, during the GATE_CYC gate
//   cycles, and HOLD_CYC cycles after the gate closes. The addressed latch
//   output is then read back and compared with the written data.
//
// Ports
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   wr_valid   : write request valid
//   wr_ready   : request can be taken (combinational: IDLE and not in reset)
//   wr_addr    : target latch index
//   wr_data    : data to write
//   lat_d      : shared latch D bus (registered, changes only on accept/reset)
//   lat_g      : one-hot gate enables, bit i drives G of latch i (registered)
//   lat_q      : latch Q outputs, latch i in bits [i*WIDTH +: WIDTH]
//   busy       : high in SETUP, GATE, HOLD and CHECK
//   done       : one-cycle completion pulse
//   mismatch   : with done, readback differed from written data
//   addr_err   : with done, wr_addr was >= NUM_LATCH (no gate was driven)
module latch_write_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_LATCH = 4,
  parameter int unsigned AW        = 2,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned GATE_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [AW-1:0]              wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           lat_d,
  output logic [NUM_LATCH-1:0]       lat_g,
  input  logic [NUM_LATCH*WIDTH-1:0] lat_q,
  output logic                       busy,
  output logic                       done,
  output logic                       mismatch,
  output logic                       addr_err
);

  // Phase counter holds (cycles - 1) of the current phase and counts to 0.
  localparam int unsigned MAX_SG  = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SG > HOLD_CYC) ? MAX_SG : HOLD_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] GATE_LD  = CW'(GATE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_GATE,
    S_HOLD,
    S_CHECK,
    S_DONE
  } state_e;

  state_e               state_q,    state_d;
  logic [CW-1:0]        cnt_q,      cnt_d;
  logic [AW-1:0]        addr_q,     addr_d;
  logic [WIDTH-1:0]     lat_d_q,    lat_d_d;
  logic [NUM_LATCH-1:0] lat_g_q,    lat_g_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 mismatch_q, mismatch_d;
  logic                 addr_err_q, addr_err_d;

  logic                 accept;
  logic                 addr_ok;
  logic [WIDTH-1:0]     rd_slice;
  logic [NUM_LATCH-1:0] gate_onehot;

  assign wr_ready = (state_q == S_IDLE) && !rst;
  assign accept   = wr_valid && wr_ready;
  assign addr_ok  = 32'(wr_addr) < NUM_LATCH;

  // Readback and gate decode use the stored address. An out-of-range
  // address never reaches GATE or CHECK, so no slice beyond the bank
  // is ever selected.
  always_comb begin
    rd_slice    = '0;
    gate_onehot = '0;
    for (int unsigned i = 0; i < NUM_LATCH; i++) begin
      if (32'(addr_q) == i) begin
        rd_slice       = lat_q[i*WIDTH +: WIDTH];
        gate_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    lat_d_d    = lat_d_q;
    mismatch_d = 1'b0;
    addr_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = wr_addr;
          lat_d_d = wr_data;
          if (addr_ok) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d    = S_DONE;
            addr_err_d = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_GATE;
          cnt_d   = GATE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_GATE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // lat_d_q still carries the written data, so it doubles as the
      // reference for the readback compare.
      S_CHECK: begin
        state_d    = S_DONE;
        mismatch_d = (rd_slice != lat_d_q);
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself; lat_g therefore rises and falls only on
    // edges where lat_d is held constant.
    lat_g_d = (state_d == S_GATE) ? gate_onehot : '0;
    busy_d  = (state_d == S_SETUP) || (state_d == S_GATE) ||
              (state_d == S_HOLD)  || (state_d == S_CHECK);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      lat_d_q    <= '0;
      lat_g_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      lat_d_q    <= lat_d_d;
      lat_g_q    <= lat_g_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign lat_d    = lat_d_q;
  assign lat_g    = lat_g_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mismatch = mismatch_q;
  assign addr_err = addr_err_q;

endmodule

// File: doc/latch_write_sequencer.md
Name: latch_write_sequencer

Overview:
- Write controller that sits directly upstream of a bank of NUM_LATCH gated D latches, each WIDTH bits wide.
- Accepts write requests over a valid/ready handshake.
- Drives the shared latch data bus and a one-hot gate vector with a guaranteed setup/gate/hold sequence.
- Reads back the addressed latch outputs and reports completion and mismatch.

Parameters:
- WIDTH, 8, data bits per latch.
- NUM_LATCH, 4, number of latches in the bank.
- AW, 2, address width; must be at least ceil(log2(NUM_LATCH)).
- SETUP_CYC, 1, cycles lat_d is stable before the gate opens; minimum 1.
- GATE_CYC, 2, cycles the gate is held high; minimum 1.
- HOLD_CYC, 1, cycles lat_d is held after the gate closes; minimum 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  sequencer can accept a request.
- wr_addr  in  AW  target latch index.
- wr_data  in  WIDTH  data to write.
- lat_d  out  WIDTH  shared D bus to all latches.
- lat_g  out  NUM_LATCH  one-hot gate enables; bit i drives G of latch i.
- lat_q  in  NUM_LATCH*WIDTH  concatenated latch Q outputs; latch i occupies bits [i*WIDTH +: WIDTH].
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when a transaction ends.
- mismatch  out  1  valid with done; readback differed from written data.
- addr_err  out  1  valid with done; wr_addr was >= NUM_LATCH.

Behaviour:
- Reset (rst high at an edge): state IDLE, lat_d=0, lat_g=0, busy=0, done=0, mismatch=0, addr_err=0, counter=0.
- wr_ready is combinational: high only when state==IDLE and rst==0.
- All other outputs are registered.
- States and transitions:
  - IDLE: on wr_valid&&wr_ready, latch addr/data internally and drive lat_d=wr_data from the next cycle.
    - If addr < NUM_LATCH, go to SETUP.
    - Otherwise go directly to DONE with addr_err=1; lat_g is never asserted for that request.
  - SETUP: lat_g=0, lat_d=data for SETUP_CYC cycles, then go to GATE.
  - GATE: lat_g[addr]=1, all other gate bits 0, for GATE_CYC cycles, then go to HOLD.
  - HOLD: lat_g=0, lat_d unchanged for HOLD_CYC cycles, then go to CHECK.
  - CHECK: one cycle. Sample lat_q slice [addr]; mismatch_next = (slice != data). Go to DONE.
  - DONE: one cycle. done=1, mismatch/addr_err valid, busy=0. Go to IDLE.
- busy=1 in SETUP, GATE, HOLD and CHECK.
- Request accepted at edge 0 with defaults:
  - SETUP occupies cycle 1.
  - GATE occupies cycles 2–3.
  - HOLD occupies cycle 4.
  - CHECK occupies cycle 5.
  - done is high in cycle 6.
- General latency from accept to done = SETUP_CYC+GATE_CYC+HOLD_CYC+2 cycles.
- Out-of-range latency = 1 cycle.
- lat_d changes only on acceptance or reset. It retains the last written value while IDLE.
- lat_g is never non-zero in the same cycle lat_d changes. At most one lat_g bit is ever high.
- wr_valid while not ready is ignored. There is no queueing; the requester holds its request until ready.
- Back-to-back: a request presented during DONE is not accepted. Acceptance is possible on the edge ending the next IDLE cycle, so there is a minimum of one IDLE cycle between transactions.
- Reset mid-transaction:
  - lat_g goes to 0 on that edge and the transaction is discarded.
  - No done pulse is produced.
  - lat_d returns to 0.
- mismatch and addr_err are 0 whenever done=0.
- The phase counter reloads on each state entry, counts down to 0, and has width sufficient for max(SETUP_CYC,GATE_CYC,HOLD_CYC).

Test Plan:
- Default parameters, latch model attached: write addr=2, data=0xA5.
  - Required: lat_d=0xA5 from cycle 1.
  - Required: lat_g=4'b0100 exactly in cycles 2–3.
  - Required: done in cycle 6 with mismatch=0; latch 2 holds 0xA5 afterwards.
- Force lat_q slice 1 to 0x00; write addr=1, data=0x3C.
  - Required: done pulse with mismatch=1, addr_err=0.
- NUM_LATCH=3, AW=2: write addr=3, data=0xFF.
  - Required: lat_g stays 0.
  - Required: done one cycle after acceptance with addr_err=1.
- Hold wr_valid high continuously with a new addr/data after each done.
  - Required: wr_ready low throughout busy/DONE.
  - Required: each request is accepted exactly once, with one IDLE cycle between transactions.
- Assert rst during the second GATE cycle of a write.
  - Required: lat_g=0 and lat_d=0 at the next edge.
  - Required: no done pulse, and wr_ready=1 on the first cycle after rst deasserts.
- SETUP_CYC=3, GATE_CYC=1, HOLD_CYC=2: single write.
  - Required: gate pulse exactly 1 cycle wide, starting 3 cycles after lat_d changes.
  - Required: done 8 cycles after acceptance.
